// File: rtl/univ_mod_counter.sv
// univ_mod_counter: up/down counter modulo MOD with programmable step,
// wrap/saturate boundary mode and a registered ovf pulse. Optional: UNIV_MOD_COUNTER_STICKY_OVF_EN.
module univ_mod_counter #(
    parameter int N   = 4,
    parameter int MOD = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
    input  logic         ovf_clr,
    output logic         ovf_sticky,
`endif
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic         sat,
    input  logic [N-1:0] step,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         ovf
);

    if (MOD < 2 || longint'(MOD) > (longint'(1) << N)) begin : g_bad_mod
        $fatal(1, "univ_mod_counter: MOD out of range 2..2**N");
    end

    localparam logic [N:0] MODV = (N+1)'(MOD);
    localparam logic [N:0] MAXV = (N+1)'(MOD - 1);

    logic [N-1:0] r_q;
    logic         r_ovf;

    logic [N:0]   w_q_ext;
    logic [N:0]   w_d_ext;
    logic [N:0]   w_step_ext;
    logic [N:0]   w_s;
    logic [N:0]   w_sum;
    logic [N:0]   w_up_wrap;
    logic [N:0]   w_dn_wrap;
    logic [N-1:0] w_q_nxt;
    logic         w_ovf_nxt;

    assign w_q_ext    = {1'b0, r_q};
    assign w_d_ext    = {1'b0, d};
    assign w_step_ext = {1'b0, step};

    // All boundary arithmetic is kept in N+1 bits so q+s never truncates.
    always_comb begin
        w_s       = w_step_ext;
        w_sum     = '0;
        w_up_wrap = '0;
        w_dn_wrap = '0;
        w_q_nxt   = r_q;
        w_ovf_nxt = 1'b0;

        if (step == '0) begin
            w_s = '0;
        end else if (w_step_ext >= MODV) begin
            w_s = MAXV;
        end

        w_sum     = w_q_ext + w_s;
        w_up_wrap = w_sum - MODV;
        w_dn_wrap = w_q_ext + MODV - w_s;

        if (syn_clr) begin
            w_q_nxt = '0;
        end else if (load) begin
            w_q_nxt = (w_d_ext > MAXV) ? MAXV[N-1:0] : d;
        end else if (en) begin
            if (up) begin
                if (w_sum <= MAXV) begin
                    w_q_nxt = w_sum[N-1:0];
                end else begin
                    w_ovf_nxt = 1'b1;
                    w_q_nxt   = sat ? MAXV[N-1:0] : w_up_wrap[N-1:0];
                end
            end else begin
                if (w_q_ext >= w_s) begin
                    w_q_nxt = r_q - w_s[N-1:0];
                end else begin
                    w_ovf_nxt = 1'b1;
                    w_q_nxt   = sat ? '0 : w_dn_wrap[N-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign q        = r_q;
    assign ovf      = r_ovf;
    assign max_tick = (w_q_ext == MAXV);
    assign min_tick = (r_q == '0);

`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
    logic r_ovf_sticky;

    // A new event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_ovf_nxt) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_univ_mod_counter.sv
// Bench for univ_mod_counter (N=4, MOD=10): vector table plus hand sequences,
// expected values queued at drive time and checked after the edge.
module tb_univ_mod_counter;

    localparam int N   = 4;
    localparam int MOD = 10;

    logic         clk;
    logic         rst;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic         sat;
    logic [N-1:0] step;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         max_tick;
    logic         min_tick;
    logic         ovf;
`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
    logic         ovf_clr;
    logic         ovf_sticky;
`endif

    univ_mod_counter #(.N(N), .MOD(MOD)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
        .ovf_clr   (ovf_clr),
        .ovf_sticky(ovf_sticky),
`endif
        .syn_clr  (syn_clr),
        .load     (load),
        .en       (en),
        .up       (up),
        .sat      (sat),
        .step     (step),
        .d        (d),
        .q        (q),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .ovf      (ovf)
    );

    typedef struct {
        logic         rst;
        logic         clr;
        logic         ld;
        logic         en;
        logic         up;
        logic         sat;
        logic [N-1:0] step;
        logic [N-1:0] d;
        logic         oc;
        logic [N-1:0] eq;
        logic         eovf;
    } vec_t;

    typedef struct {
        int           id;
        logic [N-1:0] q;
        logic         ovf;
        logic         st;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   vid   = 0;
    logic st_m  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic c, input logic l,
                                input logic e, input logic u, input logic s,
                                input int st, input int dd, input logic oc,
                                input int eq, input logic eo);
        vec_t v;
        v.rst = r; v.clr = c; v.ld = l; v.en = e; v.up = u; v.sat = s;
        v.step = N'(st); v.d = N'(dd); v.oc = oc;
        v.eq = N'(eq); v.eovf = eo;
        return v;
    endfunction

    task automatic check();
        exp_t e;
        logic bad;
        logic emax;
        logic emin;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_empty: no expected entry for observed q=%0d", q);
            return;
        end
        e = sb.pop_front();
        emax = (int'(e.q) == MOD - 1);
        emin = (e.q == '0);
        bad = (q !== e.q) || (ovf !== e.ovf) ||
              (max_tick !== emax) || (min_tick !== emin);
`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
        bad = bad || (ovf_sticky !== e.st);
`endif
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL vec%0d: got q=%0d ovf=%b max=%b min=%b, want q=%0d ovf=%b max=%b min=%b",
                     e.id, q, ovf, max_tick, min_tick, e.q, e.ovf, emax, emin);
`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
            $display("FAIL vec%0d sticky: got %b want %b", e.id, ovf_sticky, e.st);
`endif
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; syn_clr = v.clr; load = v.ld; en = v.en;
        up = v.up; sat = v.sat; step = v.step; d = v.d;
`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
        ovf_clr = v.oc;
`endif
        if (v.rst) st_m = 1'b0;
        else if (v.eovf) st_m = 1'b1;
        else if (v.oc) st_m = 1'b0;
        e.id = vid; e.q = v.eq; e.ovf = v.eovf; e.st = st_m;
        vid++;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        rst = 1'b1; syn_clr = 1'b0; load = 1'b0; en = 1'b0;
        up = 1'b0; sat = 1'b0; step = '0; d = '0;
`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        //                 rst clr ld  en  up  sat stp d   oc  q  ovf
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  7,  0, 7, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  12, 0, 9, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 1,  5,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  8,  0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1,  0,  0, 9, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1,  0,  0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1,  0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  8,  0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 3,  0,  0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,  0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  8,  0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 3,  0,  0, 9, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 3,  0,  0, 9, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 3,  0,  0, 9, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  8,  0, 8, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1,  0,  0, 9, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  2,  0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 4,  0,  0, 8, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  2,  0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 4,  0,  0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  4,  0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 4,  0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  9,  0, 9, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 15, 0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  5,  0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2,  0,  0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2,  0,  0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2,  0,  0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2,  0,  0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2,  0,  0, 7, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 2,  0,  0, 5, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  4,  0, 4, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 2,  0,  0, 6, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 2,  0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  9,  0, 9, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1,  0,  0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0,  0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  9,  0, 9, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1,  0,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 1,  0,  0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Full lap of the modulus: exactly one ovf, on the 9 -> 0 edge.
        for (int i = 0; i < MOD; i++) begin
            apply(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, (i + 1) % MOD, i == MOD - 1));
        end

        // Down lap with step 3 from 0: wrap values 7,4,1,8 (ovf on first and last).
        apply(mk(0, 0, 0, 1, 0, 0, 3, 0, 0, 7, 1));
        apply(mk(0, 0, 0, 1, 0, 0, 3, 0, 0, 4, 0));
        apply(mk(0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 0));
        apply(mk(0, 0, 0, 1, 0, 0, 3, 0, 0, 8, 1));

`ifdef UNIV_MOD_COUNTER_STICKY_OVF_EN
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 0, 9, 0, 9, 0));
        apply(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1));
        apply(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 0, 3, 0, 3, 0));
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        apply(mk(0, 0, 1, 0, 0, 0, 0, 9, 0, 9, 0));
        apply(mk(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 1));
        apply(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
`endif

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
